// File: rtl/image_in_fifo_16to64.sv
// image_in_fifo_16to64: single-clock width-converting FIFO, 16-bit writes in,
// 64-bit reads out (four pixels per read word, first-written in the low lane).
// Storage is organised as four 512 x 16 lane RAMs so that each write touches
// exactly one lane, and a read fetches all four lanes of one entry at once.
// Optional macro IMAGE_IN_FIFO_OUTREG_EN adds an output register after the
// RAM read, which makes read latency 2 cycles. Flags are not affected.

// One 16-bit lane of the storage array with a registered read port.
module image_in_fifo_lane #(
  parameter int AW = 9,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [0:(1<<AW)-1];

  // RAM write; contents are never cleared, the pointers make them invisible.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; holds its value between accepted reads.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

module image_in_fifo_16to64 #(
  parameter int WR_DEPTH_WIDTH   = 11,
  parameter int WR_DATA_WIDTH    = 16,
  parameter int RD_DEPTH_WIDTH   = 9,
  parameter int RD_DATA_WIDTH    = 64,
  parameter int ALMOST_FULL_NUM  = 1020,
  parameter int ALMOST_EMPTY_NUM = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WR_DATA_WIDTH-1:0]  wr_data,
  input  logic                      wr_en,
  output logic                      wr_full,
  output logic [WR_DEPTH_WIDTH:0]   wr_water_level,
  output logic                      almost_full,
  output logic [RD_DATA_WIDTH-1:0]  rd_data,
  input  logic                      rd_en,
  output logic                      rd_empty,
  output logic [RD_DEPTH_WIDTH:0]   rd_water_level,
  output logic                      almost_empty
);

  localparam int NUM_LANES = RD_DATA_WIDTH / WR_DATA_WIDTH;
  localparam int LANE_W    = $clog2(NUM_LANES);
  localparam int CW        = WR_DEPTH_WIDTH + 1;
  localparam int RW        = RD_DEPTH_WIDTH + 1;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_WORD = CW'(NUM_LANES);
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {WR_DEPTH_WIDTH{1'b0}}};
  localparam logic [CW-1:0] AF_TH    = CW'(ALMOST_FULL_NUM);
  localparam logic [RW-1:0] AE_TH    = RW'(ALMOST_EMPTY_NUM);
  localparam logic [RW-1:0] RP_ONE   = RW'(1);

  // Pointers carry one extra MSB so full and empty differ; the flags are
  // derived from cnt, so the MSBs only ride along.
  logic [CW-1:0] wp;
  logic [RW-1:0] rp;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          wr_ok, rd_ok;
  logic          ptr_msb_unused;

  logic [NUM_LANES-1:0][WR_DATA_WIDTH-1:0] lane_q;

  assign wr_ok          = wr_en && !wr_full;
  assign rd_ok          = rd_en && !rd_empty;
  assign wr_water_level = cnt;
  assign ptr_msb_unused = wp[CW-1] ^ rp[RW-1];

  // Next fill level in write words: +1 per write, -NUM_LANES per read.
  always_comb begin
    cnt_nxt = cnt;
    if (wr_ok) cnt_nxt = cnt_nxt + CNT_ONE;
    if (rd_ok) cnt_nxt = cnt_nxt - CNT_WORD;
  end

  // Pointers, fill count and all flags registered from the next fill level.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wp             <= '0;
      rp             <= '0;
      cnt            <= '0;
      wr_full        <= 1'b0;
      almost_full    <= 1'b0;
      rd_empty       <= 1'b1;
      almost_empty   <= 1'b1;
      rd_water_level <= '0;
    end else begin
      if (wr_ok) wp <= wp + CNT_ONE;
      if (rd_ok) rp <= rp + RP_ONE;
      cnt            <= cnt_nxt;
      wr_full        <= (cnt_nxt == CNT_FULL);
      almost_full    <= (cnt_nxt >= AF_TH);
      rd_empty       <= (cnt_nxt < CNT_WORD);
      almost_empty   <= (cnt_nxt[CW-1:LANE_W] <= AE_TH);
      rd_water_level <= cnt_nxt[CW-1:LANE_W];
    end
  end

  // One RAM per lane; a write goes to the lane selected by the low wp bits,
  // a read pulls the same entry from every lane. A read entry is always
  // complete and never the entry currently being filled.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    image_in_fifo_lane #(
      .AW (RD_DEPTH_WIDTH),
      .DW (WR_DATA_WIDTH)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr_ok && (wp[LANE_W-1:0] == LANE_W'(g))),
      .waddr (wp[WR_DEPTH_WIDTH-1:LANE_W]),
      .wdata (wr_data),
      .re    (rd_ok),
      .raddr (rp[RD_DEPTH_WIDTH-1:0]),
      .rdata (lane_q[g])
    );
  end

`ifdef IMAGE_IN_FIFO_OUTREG_EN
  logic                     rd_vld_q;
  logic [RD_DATA_WIDTH-1:0] rd_data_q;

  // Output stage: captures the RAM word one cycle after an accepted read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_vld_q <= rd_ok;
      if (rd_vld_q) rd_data_q <= lane_q;
    end
  end

  assign rd_data = rd_data_q;
`else
  assign rd_data = lane_q;
`endif

endmodule

// File: tb/tb_image_in_fifo_16to64.sv
// tb_image_in_fifo_16to64: table-driven vectors plus a scoreboard model of
// the FIFO; every cycle the flags, levels and rd_data are compared against it.
module tb_image_in_fifo_16to64;

`ifdef IMAGE_IN_FIFO_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] wr_data;
  logic        wr_en;
  logic        wr_full;
  logic [11:0] wr_water_level;
  logic        almost_full;
  logic [63:0] rd_data;
  logic        rd_en;
  logic        rd_empty;
  logic [9:0]  rd_water_level;
  logic        almost_empty;

  image_in_fifo_16to64 dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .wr_data        (wr_data),
    .wr_en          (wr_en),
    .wr_full        (wr_full),
    .wr_water_level (wr_water_level),
    .almost_full    (almost_full),
    .rd_data        (rd_data),
    .rd_en          (rd_en),
    .rd_empty       (rd_empty),
    .rd_water_level (rd_water_level),
    .almost_empty   (almost_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [15:0] wd;
    logic        re;
    int          wl;
    int          rl;
    logic        empty;
  } vec_t;

  typedef struct {
    int          due;
    logic [63:0] d;
  } pend_t;

  int          n_checks = 0;
  int          n_errors = 0;
  int          cyc      = 0;
  int          m_cnt    = 0;
  logic [15:0] mq[$];
  pend_t       pend[$];
  logic [63:0] exp_rd   = '0;
  vec_t        vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic check_state();
    chk("wr_level",     64'(wr_water_level), 64'(m_cnt));
    chk("rd_level",     64'(rd_water_level), 64'(m_cnt / 4));
    chk("wr_full",      64'(wr_full),        64'(m_cnt == 2048));
    chk("rd_empty",     64'(rd_empty),       64'(m_cnt < 4));
    chk("almost_full",  64'(almost_full),    64'(m_cnt >= 1020));
    chk("almost_empty", 64'(almost_empty),   64'((m_cnt / 4) <= 64));
    chk("rd_data",      rd_data,             exp_rd);
  endtask

  // One clock: drive at the falling edge, update the model, sample at the
  // next falling edge.
  task automatic step(input logic we, input logic [15:0] wd, input logic re);
    logic acc_w, acc_r;
    pend_t p;
    wr_en   = we;
    wr_data = wd;
    rd_en   = re;
    acc_w = we && (m_cnt != 2048);
    acc_r = re && (m_cnt >= 4);
    if (acc_r) begin
      p.due = cyc + LAT;
      p.d   = {mq[3], mq[2], mq[1], mq[0]};
      repeat (4) void'(mq.pop_front());
      pend.push_back(p);
    end
    if (acc_w) mq.push_back(wd);
    m_cnt = m_cnt + (acc_w ? 1 : 0) - (acc_r ? 4 : 0);
    @(posedge clk);
    cyc++;
    @(negedge clk);
    wr_en = 1'b0;
    rd_en = 1'b0;
    while (pend.size() > 0 && pend[0].due == cyc) begin
      exp_rd = pend[0].d;
      void'(pend.pop_front());
    end
    check_state();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    repeat (n) begin
      @(posedge clk);
      cyc++;
    end
    @(negedge clk);
    m_cnt  = 0;
    mq.delete();
    pend.delete();
    exp_rd = '0;
    check_state();
    rst_n = 1'b1;
  endtask

  function automatic logic [63:0] fill_word(input int k);
    logic [15:0] b;
    b = 16'hFFFF - 16'(4 * k);
    return {b - 16'd3, b - 16'd2, b - 16'd1, b};
  endfunction

  initial begin
    rst_n   = 1'b0;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;

    vecs[0] = '{1'b1, 16'hFFFF, 1'b0, 1, 0, 1'b1};
    vecs[1] = '{1'b1, 16'hFFFE, 1'b0, 2, 0, 1'b1};
    vecs[2] = '{1'b1, 16'hFFFD, 1'b0, 3, 0, 1'b1};
    vecs[3] = '{1'b1, 16'hFFFC, 1'b0, 4, 1, 1'b0};
    vecs[4] = '{1'b0, 16'h0000, 1'b1, 0, 0, 1'b1};
    vecs[5] = '{1'b0, 16'h0000, 1'b0, 0, 0, 1'b1};
    vecs[6] = '{1'b0, 16'h0000, 1'b1, 0, 0, 1'b1};
    vecs[7] = '{1'b1, 16'h1234, 1'b1, 1, 0, 1'b1};

    // Reset held for 20 cycles
    do_reset(20);

    // Partial word, completion, read, read-while-empty
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].we, vecs[i].wd, vecs[i].re);
      chk("vec_wl",    64'(wr_water_level), 64'(vecs[i].wl));
      chk("vec_rl",    64'(rd_water_level), 64'(vecs[i].rl));
      chk("vec_empty", 64'(rd_empty),       64'(vecs[i].empty));
    end
    chk("pack_hold", rd_data, 64'hFFFC_FFFD_FFFE_FFFF);

    // Fill with 2049 descending words; the last one is dropped
    do_reset(1);
    for (int i = 0; i < 2049; i++) begin
      step(1'b1, 16'hFFFF - 16'(i), 1'b0);
      if (i == 1018) chk("af_below", 64'(almost_full), 64'd0);
      if (i == 1019) chk("af_rise",  64'(almost_full), 64'd1);
      if (i == 2046) chk("full_below", 64'(wr_full), 64'd0);
      if (i == 2047) chk("full_rise",  64'(wr_full), 64'd1);
    end
    chk("fill_wl", 64'(wr_water_level), 64'd2048);
    chk("fill_rl", 64'(rd_water_level), 64'd512);

    // Drain with 513 reads; the last one is ignored
    for (int j = 0; j < 513; j++) begin
      step(1'b0, 16'h0000, 1'b1);
      if (j >= LAT - 1 && j - (LAT - 1) < 512)
        chk("drain_word", rd_data, fill_word(j - (LAT - 1)));
      if (j == 446) chk("ae_below", 64'(almost_empty), 64'd0);
      if (j == 447) chk("ae_rise",  64'(almost_empty), 64'd1);
    end
    repeat (LAT) step(1'b0, 16'h0000, 1'b0);
    chk("drain_empty", 64'(rd_empty), 64'd1);
    chk("drain_hold",  rd_data, fill_word(511));

    // Concurrent read and write at level 100
    do_reset(1);
    for (int i = 0; i < 100; i++) step(1'b1, 16'h1000 + 16'(i), 1'b0);
    for (int i = 0; i < 4; i++)   step(1'b1, 16'h2000 + 16'(i), 1'b1);
    chk("conc_level", 64'(wr_water_level), 64'd88);
    for (int i = 0; i < 22; i++)  step(1'b0, 16'h0000, 1'b1);
    repeat (LAT) step(1'b0, 16'h0000, 1'b0);
    chk("conc_last", rd_data, 64'h2003_2002_2001_2000);

    // Reset mid-fill at level 500, then restart from lane 0
    do_reset(1);
    for (int i = 0; i < 500; i++) step(1'b1, 16'h5000 + 16'(i), 1'b0);
    chk("mid_level", 64'(wr_water_level), 64'd500);
    do_reset(1);
    chk("mid_rst_level", 64'(wr_water_level), 64'd0);
    chk("mid_rst_empty", 64'(rd_empty), 64'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 16'hA000 + 16'(i), 1'b0);
    step(1'b0, 16'h0000, 1'b1);
    repeat (LAT) step(1'b0, 16'h0000, 1'b0);
    chk("restart_pack", rd_data, 64'hA003_A002_A001_A000);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
